data_mem_loader: RTL and testbench
==================================

Name: data_mem_loader

Overview:
- Upstream write stage for data_mem: accepts a byte stream (valid/ready) and fills the dual-port data memory from a programmable word base address.
- Packs every 4 bytes little-endian into one 32-bit word and writes it through port B.
- Writes a trailing partial word (1-3 bytes) byte-by-byte through port A, so neighbouring bytes are never clobbered.
- Reports completion and the number of words touched; sits between the host/UART byte source and data_mem.

Parameters:
- ADDR_B_W, 14, word address width (port B)
- ADDR_A_W, 16, byte address width (port A); must equal ADDR_B_W+2

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and begins a transfer (ignored while busy)
- base_addr  in  ADDR_B_W  first word address of transfer
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies final byte of transfer (sampled with in_valid)
- in_ready  out  1  loader accepts byte this cycle
- address_a  out  ADDR_A_W  data_mem port A byte address
- data_a  out  8  port A write data
- wren_a  out  1  port A write enable
- address_b  out  ADDR_B_W  data_mem port B word address
- data_b  out  32  port B write data
- wren_b  out  1  port B write enable
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer
- word_count  out  ADDR_B_W+1  words written in last/current transfer (partial word counts as 1)

Behaviour:
- Reset (reset_n=0 at rising edge): state IDLE; all outputs 0; byte index, pointer, word_count cleared. Mid-transfer reset aborts immediately; no further writes are issued.
- All memory-side outputs are registered; wren_a/wren_b high for exactly one cycle per write; never both high in the same cycle.
- IDLE: in_ready=0, busy=0. On start: ptr<=base_addr, idx<=0, word_count<=0, go FILL.
- FILL: busy=1, in_ready=1. A byte is accepted when in_valid&&in_ready; stored in lane idx (bits 8*idx+7:8*idx). idx increments.
  - Accept with idx==3 -> go WRITE.
  - Accept with in_last and idx<3 -> go FLUSH with k=idx+1 bytes pending.
- WRITE: in_ready=0; wren_b=1, address_b=ptr, data_b=packed word; word_count++, ptr<=ptr+1 (wraps modulo 2^ADDR_B_W, no error), idx<=0. Go DONE if the accepted 4th byte had in_last, else FILL. One bubble cycle per word; peak throughput 4 bytes / 5 cycles.
- FLUSH: in_ready=0; issue k consecutive cycles with wren_a=1, address_a={ptr,2'b00}+i, data_a=lane i, i=0..k-1; then word_count++, ptr++, go DONE. Lanes >= k are never written.
- DONE: done=1 for one cycle, busy=0, in_ready=0; go IDLE. word_count holds until next start.
- start while busy: ignored. in_last without in_valid: ignored. in_valid while in_ready=0: byte not consumed (source must hold).
- Write-to-memory latency: the word is presented on port B the cycle after its 4th byte is accepted.

Optional Feature:
- Macro LOADER_BYTE_SWAP_EN.
- Defined: big-endian packing; the first byte of each group lands in bits 31:24. FLUSH writes lane i to address {ptr,2'b00}+i, with data taken from the big-endian byte position.
- Undefined: little-endian packing as above.

Test Plan:
- Reset: assert reset_n=0 mid-FILL with 2 bytes accepted -> next cycle all outputs 0, state IDLE, no wren_a/wren_b afterwards.
- Full word: start, base_addr=0x0010, bytes 0x11,0x22,0x33,0x44 (last on 0x44) -> single wren_b cycle, address_b=0x0010, data_b=0x44332211; done pulse; word_count=1.
- Partial flush: base_addr=0x0002, bytes 0xAA..0xAE (5 bytes, last on 0xAE) -> wren_b addr 0x0002 data 0xADACABAA; then one wren_a at address_a=0x000C, data_a=0xAE; word_count=2.
- Wrap: base_addr=0x3FFF, 8 bytes -> writes at word 0x3FFF then 0x0000; done; word_count=2.
- Backpressure/start-ignore: drop in_valid for 3 cycles between bytes and pulse start mid-transfer -> packed data unchanged, ptr unchanged, in_ready=0 during WRITE cycle.
- With LOADER_BYTE_SWAP_EN: bytes 0x11,0x22,0x33,0x44 -> data_b=0x11223344.

Source files
------------

// File: rtl/data_mem_loader.sv
`timescale 1ns/1ps
// data_mem_loader: byte-stream to data_mem write stage.
// Packs 4 bytes into one 32-bit word and writes it through port B.
// A trailing 1-3 byte remainder is written byte-by-byte through port A,
// so bytes after the end of the stream stay untouched.
// Optional macro LOADER_BYTE_SWAP_EN: big-endian packing (first byte in 31:24).
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   start, base_addr        : begin a transfer at a word address (ignored unless idle)
//   in_data/in_valid/in_last/in_ready : byte stream handshake
//   address_a/data_a/wren_a : port A byte writes (partial-word flush)
//   address_b/data_b/wren_b : port B word writes
//   busy, done, word_count  : transfer status; word_count holds until next start
// ADDR_A_W must equal ADDR_B_W+2.
module data_mem_loader #(
  parameter int unsigned ADDR_B_W = 14,
  parameter int unsigned ADDR_A_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_B_W-1:0] base_addr,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ADDR_A_W-1:0] address_a,
  output logic [7:0]          data_a,
  output logic                wren_a,
  output logic [ADDR_B_W-1:0] address_b,
  output logic [31:0]         data_b,
  output logic                wren_b,
  output logic                busy,
  output logic                done,
  output logic [ADDR_B_W:0]   word_count
);

  localparam int unsigned WC_W = ADDR_B_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_FLUSH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          k_q, k_d;
  logic [1:0]          fi_q, fi_d;
  logic                last_q, last_d;
  logic [ADDR_B_W-1:0] ptr_q, ptr_d;
  logic [31:0]         word_q, word_d;
  logic [WC_W-1:0]     wc_q, wc_d;

  logic                in_ready_d, busy_d, done_d, wren_a_d, wren_b_d;
  logic [ADDR_A_W-1:0] address_a_d;
  logic [7:0]          data_a_d;
  logic [ADDR_B_W-1:0] address_b_d;
  logic [31:0]         data_b_d;

  logic                accept_c;
  logic [31:0]         word_ins_c;

  // Bit position (in bytes) of the n-th byte of a group.
  function automatic logic [1:0] lane_pos(input logic [1:0] n);
`ifdef LOADER_BYTE_SWAP_EN
    return 2'd3 - n;
`else
    return n;
`endif
  endfunction

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    fi_d        = fi_q;
    last_d      = last_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    wc_d        = wc_q;
    wren_a_d    = 1'b0;
    wren_b_d    = 1'b0;
    address_a_d = address_a;
    data_a_d    = data_a;
    address_b_d = address_b;
    data_b_d    = data_b;

    accept_c   = in_ready && in_valid;
    word_ins_c = word_q;
    word_ins_c[{lane_pos(idx_q), 3'b000} +: 8] = in_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          idx_d   = 2'd0;
          wc_d    = '0;
          word_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (accept_c) begin
          word_d = word_ins_c;
          idx_d  = idx_q + 2'd1;
          last_d = in_last;
          if (idx_q == 2'd3) begin
            // Word complete: present it on port B in the following cycle.
            state_d     = S_WRITE;
            wren_b_d    = 1'b1;
            address_b_d = ptr_q;
            data_b_d    = word_ins_c;
          end else if (in_last) begin
            // Remainder: first byte goes out now, the rest from FLUSH.
            state_d     = S_FLUSH;
            k_d         = idx_q + 2'd1;
            fi_d        = 2'd1;
            wren_a_d    = 1'b1;
            address_a_d = ADDR_A_W'({ptr_q, 2'b00});
            data_a_d    = word_ins_c[{lane_pos(2'd0), 3'b000} +: 8];
          end
        end
      end
      S_WRITE: begin
        wc_d    = wc_q + WC_W'(1);
        ptr_d   = ptr_q + ADDR_B_W'(1);
        idx_d   = 2'd0;
        word_d  = '0;
        state_d = last_q ? S_DONE : S_FILL;
      end
      S_FLUSH: begin
        if (fi_q != k_q) begin
          wren_a_d    = 1'b1;
          address_a_d = ADDR_A_W'({ptr_q, fi_q});
          data_a_d    = word_q[{lane_pos(fi_q), 3'b000} +: 8];
          fi_d        = fi_q + 2'd1;
        end else begin
          wc_d    = wc_q + WC_W'(1);
          ptr_d   = ptr_q + ADDR_B_W'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_FILL);
    busy_d     = (state_d == S_FILL) || (state_d == S_WRITE) || (state_d == S_FLUSH);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      k_q        <= '0;
      fi_q       <= '0;
      last_q     <= 1'b0;
      ptr_q      <= '0;
      word_q     <= '0;
      wc_q       <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wren_a     <= 1'b0;
      wren_b     <= 1'b0;
      address_a  <= '0;
      data_a     <= '0;
      address_b  <= '0;
      data_b     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      fi_q       <= fi_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      word_q     <= word_d;
      wc_q       <= wc_d;
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      wren_a     <= wren_a_d;
      wren_b     <= wren_b_d;
      address_a  <= address_a_d;
      data_a     <= data_a_d;
      address_b  <= address_b_d;
      data_b     <= data_b_d;
    end
  end

  assign word_count = wc_q;

endmodule

// File: tb/tb_data_mem_loader.sv
`timescale 1ns/1ps
// Directed self-checking bench for data_mem_loader.
module tb_data_mem_loader;

  localparam int unsigned ADDR_B_W = 14;
  localparam int unsigned ADDR_A_W = 16;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start;
  logic [ADDR_B_W-1:0] base_addr;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [ADDR_A_W-1:0] address_a;
  logic [7:0]          data_a;
  logic                wren_a;
  logic [ADDR_B_W-1:0] address_b;
  logic [31:0]         data_b;
  logic                wren_b;
  logic                busy;
  logic                done;
  logic [ADDR_B_W:0]   word_count;

  data_mem_loader #(.ADDR_B_W(ADDR_B_W), .ADDR_A_W(ADDR_A_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [ADDR_B_W-1:0] wb_addr_q[$];
  logic [31:0]         wb_data_q[$];
  logic [ADDR_A_W-1:0] wa_addr_q[$];
  logic [7:0]          wa_data_q[$];
  int                  both_cnt = 0;
  int                  rdy_in_write = 0;

  // Write log, sampled mid-cycle.
  always @(negedge clock) begin
    if (wren_b) begin
      wb_addr_q.push_back(address_b);
      wb_data_q.push_back(data_b);
    end
    if (wren_a) begin
      wa_addr_q.push_back(address_a);
      wa_data_q.push_back(data_a);
    end
    if (wren_a && wren_b) both_cnt++;
    if (wren_b && in_ready) rdy_in_write++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wb_addr_q.delete(); wb_data_q.delete();
    wa_addr_q.delete(); wa_data_q.delete();
  endtask

  task automatic do_start(input logic [ADDR_B_W-1:0] a);
    @(posedge clock); #1;
    start = 1'b1; base_addr = a;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    logic got;
    got = 1'b0;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (in_ready) begin got = 1'b1; break; end
    end
    chk("accept", 32'(got), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait for done, check word_count while it is high, then check the pulse ends.
  task automatic wait_done(input string tag, input logic [31:0] wc_exp);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), wc_exp);
    @(negedge clock);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_wc_hold"}, 32'(word_count), wc_exp);
    #1;
  endtask

  logic [31:0] exp_w0, exp_w1, exp_w2;

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren_b", 32'(wren_b), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Full word
    do_start(14'h0010);
    clear_log();
    chk("fill_busy", 32'(busy), 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    chk("full_wren_b_lat", 32'(wren_b), 32'd1);
    chk("full_ready_in_write", 32'(in_ready), 32'd0);
    wait_done("full", 32'd1);
`ifdef LOADER_BYTE_SWAP_EN
    exp_w0 = 32'h11223344;
`else
    exp_w0 = 32'h44332211;
`endif
    chk("full_nb", 32'(wb_addr_q.size()), 32'd1);
    chk("full_addr", 32'(wb_addr_q[0]), 32'h0010);
    chk("full_data", wb_data_q[0], exp_w0);
    chk("full_na", 32'(wa_addr_q.size()), 32'd0);

    // Word plus one-byte remainder
    do_start(14'h0002);
    clear_log();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hAC, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hAE, 1'b1);
    wait_done("part", 32'd2);
`ifdef LOADER_BYTE_SWAP_EN
    exp_w0 = 32'hAAABACAD;
`else
    exp_w0 = 32'hADACABAA;
`endif
    chk("part_nb", 32'(wb_addr_q.size()), 32'd1);
    chk("part_baddr", 32'(wb_addr_q[0]), 32'h0002);
    chk("part_bdata", wb_data_q[0], exp_w0);
    chk("part_na", 32'(wa_addr_q.size()), 32'd1);
    chk("part_aaddr", 32'(wa_addr_q[0]), 32'h000C);
    chk("part_adata", 32'(wa_data_q[0]), 32'h00AE);

    // Three-byte remainder only
    do_start(14'h0100);
    clear_log();
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    wait_done("rem3", 32'd1);
    chk("rem3_nb", 32'(wb_addr_q.size()), 32'd0);
    chk("rem3_na", 32'(wa_addr_q.size()), 32'd3);
    chk("rem3_a0", 32'(wa_addr_q[0]), 32'h0400);
    chk("rem3_a2", 32'(wa_addr_q[2]), 32'h0402);
    chk("rem3_d0", 32'(wa_data_q[0]), 32'h00C1);
    chk("rem3_d1", 32'(wa_data_q[1]), 32'h00C2);
    chk("rem3_d2", 32'(wa_data_q[2]), 32'h00C3);

    // Address wrap
    do_start(14'h3FFF);
    clear_log();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    wait_done("wrap", 32'd2);
`ifdef LOADER_BYTE_SWAP_EN
    exp_w1 = 32'h01020304; exp_w2 = 32'h05060708;
`else
    exp_w1 = 32'h04030201; exp_w2 = 32'h08070605;
`endif
    chk("wrap_nb", 32'(wb_addr_q.size()), 32'd2);
    chk("wrap_addr0", 32'(wb_addr_q[0]), 32'h3FFF);
    chk("wrap_addr1", 32'(wb_addr_q[1]), 32'h0000);
    chk("wrap_data0", wb_data_q[0], exp_w1);
    chk("wrap_data1", wb_data_q[1], exp_w2);

    // Backpressure gaps and an ignored start
    do_start(14'h0020);
    clear_log();
    send_byte(8'h01, 1'b0);
    idle(3);
    do_start(14'h0030);
    send_byte(8'h02, 1'b0);
    idle(3);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    chk("bp_wren_b_lat", 32'(wren_b), 32'd1);
    chk("bp_ready_in_write", 32'(in_ready), 32'd0);
    wait_done("bp", 32'd1);
    chk("bp_nb", 32'(wb_addr_q.size()), 32'd1);
    chk("bp_addr", 32'(wb_addr_q[0]), 32'h0020);
    chk("bp_data", wb_data_q[0], exp_w1);

    // Reset in the middle of a fill
    do_start(14'h0040);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_wren_a", 32'(wren_a), 32'd0);
    chk("mrst_wren_b", 32'(wren_b), 32'd0);
    chk("mrst_address_a", 32'(address_a), 32'd0);
    chk("mrst_data_a", 32'(data_a), 32'd0);
    chk("mrst_address_b", 32'(address_b), 32'd0);
    chk("mrst_data_b", data_b, 32'd0);
    chk("mrst_wc", 32'(word_count), 32'd0);
    clear_log();
    reset_n = 1'b1;
    in_data = 8'h77; in_valid = 1'b1; in_last = 1'b1;
    idle(5);
    chk("mrst_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    idle(10);
    chk("mrst_no_wb", 32'(wb_addr_q.size()), 32'd0);
    chk("mrst_no_wa", 32'(wa_addr_q.size()), 32'd0);

    chk("never_both_wren", 32'(both_cnt), 32'd0);
    chk("never_ready_with_wren_b", 32'(rdy_in_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
